spi_monarch_16: RTL and testbench
=================================

// Module: spi_monarch_16
// PURPOSE
//  16-bit SPI monarch (mode 3: SCLK idles high, MOSI launched on SCLK fall, MISO sampled on rise).
//  Sits directly downstream of the inertial-sensor interface FSM, which drives wrt/wt_data and
//  consumes done/rd_data. Carries the config writes (0x0D02, 0x1160, 0x1440) and the yaw-register
//  reads (0xA6xx, 0xA7xx) to the 6-axis sensor.
// PARAMETERS
//  DIV_W  4  SCLK divider width. SCLK period = 2**DIV_W clk (16 at default). Minimum 3.
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   reset, asynchronous, active-low
//  wrt      in   1   start transaction, 1-clk pulse; ignored unless IDLE
//  wt_data  in   16  word to send MSB-first; captured on the wrt cycle
//  MISO     in   1   serial data from sensor
//  SS_n     out  1   slave select, active-low, registered
//  SCLK     out  1   serial clock = MSB of divider, forced high outside SHIFT
//  MOSI     out  1   shift_reg[15]
//  done     out  1   transaction complete; stays high until the next accepted wrt
//  rd_data  out  16  word received MSB-first = shift_reg; valid while done is high
// BEHAVIOUR
//  Reset: SS_n=1, SCLK=1, done=0, shift_reg=0 (so MOSI=0 and rd_data=0), div=0, bit_cnt=0, state=IDLE.
//  Regs: div[DIV_W-1:0], bit_cnt[4:0] (count of MISO samples), miso_smpl, shift_reg[15:0], state.
//  Constants: FRONT = 2**DIV_W-5 (4'b1011). SMPL = 2**(DIV_W-1)-1 (4'b0111). MAXV = all ones.
//  IDLE: div held, SCLK=1.
//   - wrt=1 captures wt_data into shift_reg, sets div=FRONT, bit_cnt=0, SS_n=0, done=0.
//   - Then go to SHIFT.
//  SHIFT: div increments every clk.
//   - div==SMPL: miso_smpl<=MISO; bit_cnt++. SCLK rises on the next cycle.
//   - div==MAXV with 0<bit_cnt<16: shift_reg<={shift_reg[14:0],miso_smpl}. SCLK falls next cycle.
//   - div==MAXV with bit_cnt==0 is the front porch: no shift.
//   - div==SMPL taking bit_cnt to 16: go to BACK.
//  BACK: SCLK forced high, div keeps counting.
//   - At div==MAXV: final shift (16th), SS_n<=1, done<=1, state<=IDLE.
//  Latency (DIV_W=4): call the wrt cycle t=0.
//   - Sample cycles t=13+16k, k=0..15. Shift cycles t=21+16k, k=0..14.
//   - Final shift at t=261; SS_n=1 and done=1 first visible at t=262.
//  Outputs: SCLK low exactly while state==SHIFT and div[MSB]==0, giving 16 low pulses of
//   2**(DIV_W-1) clk. No SCLK edge occurs while SS_n=1.
//  Boundaries:
//   - wrt while SHIFT/BACK: ignored. Transaction unaffected, shift_reg not reloaded.
//   - wrt on the same cycle done rises: not possible; done rises only when entering IDLE.
//   - wrt in the first IDLE cycle after done: accepted. done clears next cycle and a new
//     transaction starts, giving back-to-back operation.
//   - done=1 held across idle gaps; rd_data stable until next wrt.
//   - rst_n low mid-transaction: immediate return to reset values. SS_n high asynchronously,
//     no further SCLK edges, partial data discarded.
//   - bit_cnt saturates logic at 16; never wraps.
// TESTING
//  1 Reset: rst_n=0 -> SS_n=1, SCLK=1, done=0, rd_data=0, MOSI=0; no toggles for 100 clk idle.
//  2 wrt with wt_data=16'hA600, SPI sensor model returning 16'h00C3:
//    -> MOSI bits on 16 rising edges = A600; rd_data=16'h00C3; done first high at t=262;
//    -> exactly 16 SCLK falls while SS_n=0.
//  3 wt_data=16'h0D02, then wrt the cycle done rises, with 16'h1160:
//    -> second frame correct; SS_n high >=1 clk between frames; done low at t=1 of frame 2.
//  4 wrt pulsed at t=50 and t=150 mid-frame with wt_data=16'hFFFF:
//    -> ignored; frame completes with original data.
//  5 rst_n asserted at t=120 mid-frame -> SS_n=1, SCLK=1 same cycle; new wrt afterward completes normally.
//  6 DIV_W=5 with wt_data=16'h1440 -> SCLK period 32 clk, 16 pulses; rd_data matches model.

Source files
------------

// File: rtl/spi_monarch_16.sv
// 16-bit SPI monarch, mode 3 (SCLK idles high, MOSI launched on fall, MISO sampled on rise).
// One free-running divider sets the SCLK phase; bit_cnt counts MISO samples taken.
module spi_monarch_16 #(
   parameter int DIV_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] wt_data,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic        done,
   output logic [15:0] rd_data
);

   localparam logic [DIV_W-1:0] FRONT = DIV_W'((1 << DIV_W) - 5);
   localparam logic [DIV_W-1:0] SMPL  = DIV_W'((1 << (DIV_W - 1)) - 1);
   localparam logic [DIV_W-1:0] MAXV  = '1;

   typedef enum logic [1:0] {IDLE, SHIFT, BACK} state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div, div_nxt;
   logic [4:0]        bit_cnt, bit_cnt_nxt;
   logic              miso_smpl, miso_smpl_nxt;
   logic [15:0]       shift_reg, shift_reg_nxt;
   logic              ss_n_nxt, done_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         div       <= '0;
         bit_cnt   <= '0;
         miso_smpl <= 1'b0;
         shift_reg <= '0;
         SS_n      <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div       <= div_nxt;
         bit_cnt   <= bit_cnt_nxt;
         miso_smpl <= miso_smpl_nxt;
         shift_reg <= shift_reg_nxt;
         SS_n      <= ss_n_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      div_nxt       = div;
      bit_cnt_nxt   = bit_cnt;
      miso_smpl_nxt = miso_smpl;
      shift_reg_nxt = shift_reg;
      ss_n_nxt      = SS_n;
      done_nxt      = done;
      case (state)
         IDLE: begin
            if (wrt) begin
               shift_reg_nxt = wt_data;
               div_nxt       = FRONT;
               bit_cnt_nxt   = '0;
               ss_n_nxt      = 1'b0;
               done_nxt      = 1'b0;
               state_nxt     = SHIFT;
            end
         end
         SHIFT: begin
            div_nxt = div + DIV_W'(1);
            // SMPL and MAXV never coincide, so sample and shift are exclusive
            if (div == SMPL) begin
               miso_smpl_nxt = MISO;
               if (bit_cnt != 5'd16)
                  bit_cnt_nxt = bit_cnt + 5'd1;
               if (bit_cnt == 5'd15)
                  state_nxt = BACK;
            end
            if (div == MAXV && bit_cnt != 5'd0 && bit_cnt < 5'd16)
               shift_reg_nxt = {shift_reg[14:0], miso_smpl};
         end
         BACK: begin
            div_nxt = div + DIV_W'(1);
            if (div == MAXV) begin
               shift_reg_nxt = {shift_reg[14:0], miso_smpl};
               ss_n_nxt      = 1'b1;
               done_nxt      = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign SCLK    = (state == SHIFT) ? div[DIV_W-1] : 1'b1;
   assign MOSI    = shift_reg[15];
   assign rd_data = shift_reg;

endmodule

// File: tb/tb_spi_monarch_16.sv
// Directed bench for spi_monarch_16: one DUT at DIV_W=4, one at DIV_W=5, each with a
// mode-3 sensor model that shifts out a response word and captures MOSI on SCLK rise.
module tb_spi_monarch_16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wrt4 = 1'b0, wrt5 = 1'b0;
   logic [15:0] wt4 = '0, wt5 = '0;
   logic        miso4, miso5;
   logic        ss4, sclk4, mosi4, done4;
   logic        ss5, sclk5, mosi5, done5;
   logic [15:0] rd4, rd5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_monarch_16 #(.DIV_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .wrt(wrt4), .wt_data(wt4), .MISO(miso4),
      .SS_n(ss4), .SCLK(sclk4), .MOSI(mosi4), .done(done4), .rd_data(rd4));

   spi_monarch_16 #(.DIV_W(5)) u5 (
      .clk(clk), .rst_n(rst_n), .wrt(wrt5), .wt_data(wt5), .MISO(miso5),
      .SS_n(ss5), .SCLK(sclk5), .MOSI(mosi5), .done(done5), .rd_data(rd5));

   // Sensor models: present resp[idx] on MISO, advance after every SCLK rise while selected
   logic [15:0] resp4 = '0, resp5 = '0;
   logic [15:0] cap4 = '0, cap5 = '0;
   int idx4 = -1, idx5 = -1;
   int falls4 = 0, falls5 = 0, tog4 = 0, stray4 = 0;

   assign miso4 = (idx4 >= 0) ? resp4[idx4[3:0]] : 1'b0;
   assign miso5 = (idx5 >= 0) ? resp5[idx5[3:0]] : 1'b0;

   always @(negedge ss4) begin idx4 = 15; cap4 = '0; end
   always @(negedge ss5) begin idx5 = 15; cap5 = '0; end
   always @(posedge sclk4) if (!ss4 && rst_n) begin cap4 = {cap4[14:0], mosi4}; idx4 = idx4 - 1; end
   always @(posedge sclk5) if (!ss5 && rst_n) begin cap5 = {cap5[14:0], mosi5}; idx5 = idx5 - 1; end
   always @(negedge sclk4) if (!ss4) falls4++;
   always @(negedge sclk5) if (!ss5) falls5++;
   always @(sclk4 or ss4) tog4++;
   always @(sclk4) if (ss4) stray4++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge of the wrt cycle (t=0); returns at t=262 with the frame checked
   task automatic frame4(input string tag, input logic [15:0] d, input logic [15:0] r);
      int f0;
      resp4 = r;
      wt4   = d;
      wrt4  = 1'b1;
      f0    = falls4;
      @(negedge clk);
      wrt4 = 1'b0;
      chk({tag, "_done_t1"}, done4, 1'b0);
      chk({tag, "_ss_t1"}, ss4, 1'b0);
      repeat (260) @(negedge clk);
      chk({tag, "_done_t261"}, done4, 1'b0);
      @(negedge clk);
      chk({tag, "_done_t262"}, done4, 1'b1);
      chk({tag, "_ss_t262"}, ss4, 1'b1);
      chk({tag, "_rd"}, rd4, r);
      chk({tag, "_mosi"}, cap4, d);
      chk({tag, "_falls"}, falls4 - f0, 16);
   endtask

   initial begin
      int f, s, t;

      // Reset state and quiet idle
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ss", ss4, 1'b1);
      chk("rst_sclk", sclk4, 1'b1);
      chk("rst_done", done4, 1'b0);
      chk("rst_rd", rd4, 16'h0000);
      chk("rst_mosi", mosi4, 1'b0);
      rst_n = 1'b1;
      t = tog4;
      repeat (100) @(negedge clk);
      chk("idle_toggles", tog4 - t, 0);

      // Single read frame with SCLK phase checks
      resp4 = 16'h00C3;
      wt4   = 16'hA600;
      wrt4  = 1'b1;
      f = falls4;
      s = stray4;
      @(negedge clk);
      wrt4 = 1'b0;
      chk("a6_done_t1", done4, 1'b0);
      chk("a6_ss_t1", ss4, 1'b0);
      chk("a6_sclk_t1", sclk4, 1'b1);
      repeat (4) @(negedge clk);
      chk("a6_sclk_t5", sclk4, 1'b1);
      @(negedge clk);
      chk("a6_sclk_t6", sclk4, 1'b0);
      repeat (7) @(negedge clk);
      chk("a6_sclk_t13", sclk4, 1'b0);
      @(negedge clk);
      chk("a6_sclk_t14", sclk4, 1'b1);
      repeat (247) @(negedge clk);
      chk("a6_done_t261", done4, 1'b0);
      @(negedge clk);
      chk("a6_done_t262", done4, 1'b1);
      chk("a6_ss_t262", ss4, 1'b1);
      chk("a6_rd", rd4, 16'h00C3);
      chk("a6_mosi", cap4, 16'hA600);
      chk("a6_falls", falls4 - f, 16);
      chk("a6_stray", stray4 - s, 0);
      repeat (5) @(negedge clk);
      chk("a6_done_held", done4, 1'b1);
      chk("a6_rd_held", rd4, 16'h00C3);

      // Back-to-back: second wrt in the first IDLE cycle after done
      frame4("cfg1", 16'h0D02, 16'h5A3C);
      frame4("cfg2", 16'h1160, 16'h0F0F);

      // wrt pulses mid-frame are ignored
      repeat (3) @(negedge clk);
      resp4 = 16'h1234;
      wt4   = 16'hA700;
      wrt4  = 1'b1;
      f = falls4;
      @(negedge clk);
      wrt4 = 1'b0;
      repeat (49) @(negedge clk);
      wt4  = 16'hFFFF;
      wrt4 = 1'b1;
      @(negedge clk);
      wrt4 = 1'b0;
      repeat (99) @(negedge clk);
      wrt4 = 1'b1;
      @(negedge clk);
      wrt4 = 1'b0;
      repeat (110) @(negedge clk);
      chk("ign_done_t261", done4, 1'b0);
      @(negedge clk);
      chk("ign_done_t262", done4, 1'b1);
      chk("ign_rd", rd4, 16'h1234);
      chk("ign_mosi", cap4, 16'hA700);
      chk("ign_falls", falls4 - f, 16);

      // Asynchronous reset mid-frame, then a normal frame
      repeat (2) @(negedge clk);
      resp4 = 16'h7777;
      wt4   = 16'h0D02;
      wrt4  = 1'b1;
      @(negedge clk);
      wrt4 = 1'b0;
      repeat (119) @(negedge clk);
      chk("mid_sclk_low", sclk4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ss", ss4, 1'b1);
      chk("mid_rst_sclk", sclk4, 1'b1);
      chk("mid_rst_done", done4, 1'b0);
      chk("mid_rst_rd", rd4, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      s = stray4;
      frame4("rec", 16'h1440, 16'hBEEF);
      chk("rec_stray", stray4 - s, 0);

      // DIV_W=5: 32-clk SCLK period
      resp5 = 16'hC3A5;
      wt5   = 16'h1440;
      wrt5  = 1'b1;
      f = falls5;
      @(negedge clk);
      wrt5 = 1'b0;
      chk("d5_ss_t1", ss5, 1'b0);
      repeat (4) @(negedge clk);
      chk("d5_sclk_t5", sclk5, 1'b1);
      @(negedge clk);
      chk("d5_sclk_t6", sclk5, 1'b0);
      repeat (15) @(negedge clk);
      chk("d5_sclk_t21", sclk5, 1'b0);
      @(negedge clk);
      chk("d5_sclk_t22", sclk5, 1'b1);
      repeat (16) @(negedge clk);
      chk("d5_sclk_t38", sclk5, 1'b0);
      repeat (479) @(negedge clk);
      chk("d5_done_t517", done5, 1'b0);
      @(negedge clk);
      chk("d5_done_t518", done5, 1'b1);
      chk("d5_ss_t518", ss5, 1'b1);
      chk("d5_rd", rd5, 16'hC3A5);
      chk("d5_mosi", cap5, 16'h1440);
      chk("d5_falls", falls5 - f, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
